cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter ADDR_BITS, 32, byte-address width; the address is split as tag[31:9], index[8:4], word[3:2], byte[1:0].
REQ-002 Parameter LINE_WORDS, 4, words per cache line; word counter width is 2.
REQ-003 One clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 clk  in  1  clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en_r / en_w  in  1 each  CPU read / write request; the CPU holds each request stable while stall=1.
REQ-007 addr_rw  in  32  CPU byte address.
REQ-008 u_b_h_w  in  3  CPU access width and signedness (RV32I LB/LH/LW/LBU/LHU encoding).
REQ-009 data_w  in  32  CPU store data.
REQ-010 data_r  out  32  CPU load data.
REQ-011 stall  out  1  CPU must hold its request.
REQ-012 cache_addr, cache_load, cache_store, cache_edit, cache_invalid, cache_u_b_h_w[2:0], cache_din[31:0]  out  drive the cache array.
REQ-013 cache_hit, cache_valid, cache_dirty, cache_tag[22:0], cache_dout[31:0]  in  registered cache status (one-cycle latency); cache_tag is the victim tag.
REQ-014 mem_cs_o, mem_we_o  out  1 each  memory select and write enable.
REQ-015 mem_addr_o, mem_data_o  out  32 each  memory word address and write data.
REQ-016 mem_data_i  in  32  memory read data.
REQ-017 mem_ack_i  in  1  single-cycle pulse completing the current memory word.

Function
REQ-018 States: S_IDLE, S_LOOKUP, S_PRE_BACK, S_BACK, S_FILL, S_WAIT; 2-bit word_cnt.
REQ-019 S_IDLE, request present: drive cache_addr=addr_rw and cache_u_b_h_w=u_b_h_w, cache_din=data_w, cache_load=en_r&~en_w, cache_edit=en_w; go to S_LOOKUP; no request: all cache strobes 0, remain idle.
REQ-020 en_r and en_w together: treated as a write.
REQ-021 stall = (en_r|en_w) & ~(state==S_LOOKUP & cache_hit), combinational.
REQ-022 S_LOOKUP, cache_hit=1: data_r=cache_dout; return to S_IDLE; hit latency is 2 cycles.
REQ-023 S_LOOKUP miss, cache_valid&cache_dirty: latch the victim tag; word_cnt=0; go to S_PRE_BACK; otherwise word_cnt=0 and go to S_FILL.
REQ-024 S_PRE_BACK: cache_addr={victim line index, word_cnt, 2'b00}, cache_load=0, cache_store=0, cache_edit=0; go to S_BACK next cycle.
REQ-025 S_BACK: mem_cs_o=1, mem_we_o=1, mem_addr_o={victim tag, index, word_cnt, 2'b00}, mem_data_o=cache_dout; hold until mem_ack_i.
REQ-026 S_BACK, on ack: if word_cnt==3, set word_cnt=0 and go to S_FILL; otherwise increment word_cnt and go to S_PRE_BACK.
REQ-027 S_FILL: mem_cs_o=1, mem_we_o=0, mem_addr_o={request tag, index, word_cnt, 2'b00}; hold until ack.
REQ-028 S_FILL, ack cycle: cache_store=1, cache_addr=same word, cache_din=mem_data_i, cache_u_b_h_w=3'b010.
REQ-029 S_FILL, after ack: if word_cnt==3, go to S_WAIT; otherwise increment word_cnt, which wraps to 0.
REQ-030 S_WAIT: one settle cycle, then S_IDLE; the CPU request replays from S_IDLE and hits.
REQ-031 mem_cs_o=0 in S_IDLE, S_LOOKUP, S_PRE_BACK and S_WAIT; cache_invalid is tied 0.
REQ-032 mem_ack_i outside S_BACK/S_FILL: ignored.
REQ-033 Request withdrawn in S_LOOKUP: return to S_IDLE with no cache update beyond the cycle-0 access.
REQ-034 Request withdrawn during a refill: the refill completes.

Reset
REQ-035 rst=1 at posedge: state=S_IDLE, word_cnt=0, victim tag=0, data_r=0.
REQ-036 While rst=1, all cache strobes and mem_cs_o/mem_we_o are 0, with effect at the same posedge.
REQ-037 Reset in any state, including mid-burst, aborts the burst; no partial-line valid tracking is required.

Verification
REQ-038 Cold read: en_r=1, addr=0x0000_0104, LW -> clean miss; 4 reads at 0x100..0x10C, each acked after 2 cycles; 4 cache_store pulses; S_WAIT; replay; stall falls in the LOOKUP cycle; data_r=mem[0x104].
REQ-039 Read hit on the same line: addr 0x108, LW -> stall=1 for exactly 1 cycle, then data_r=mem[0x108].
REQ-040 Write hit: en_w, addr 0x10A, SH, data_w=0xBEEF -> cache_edit=1 in the IDLE cycle; stall low in LOOKUP; no memory traffic.
REQ-041 Dirty eviction: fill both ways of index 0x10 dirty, then read tag+2 -> 4 writes with mem_we_o=1 at the victim address in word order 0..3, data equal to prior cache contents; then 4 reads, then a hit.
REQ-042 Reset after the 2nd ack of a fill -> next cycle state=S_IDLE, mem_cs_o=0, stall follows the request only.
REQ-043 Simultaneous en_r=en_w=1 -> cache_load=0, cache_edit=1; treated as a write.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: blocking cache controller between an RV32 CPU port, an external
// cache array (registered status, one-cycle latency) and a word-wide memory.
// Performs hit/miss lookup, dirty-line write-back and four-word line refill.
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   en_r, en_w, addr_rw, u_b_h_w, data_w CPU request (held while stall=1)
//   data_r, stall                        CPU load data, hold-request indication
//   cache_addr/load/store/edit/invalid,
//   cache_u_b_h_w, cache_din             cache array command
//   cache_hit/valid/dirty/tag/dout       cache array status (victim tag)
//   mem_cs_o, mem_we_o, mem_addr_o,
//   mem_data_o, mem_data_i, mem_ack_i    memory word port, single-cycle ack
module cache_ctrl #(
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_r,
    input  logic                  en_w,
    input  logic [ADDR_BITS-1:0]  addr_rw,
    input  logic [2:0]            u_b_h_w,
    input  logic [31:0]           data_w,
    output logic [31:0]           data_r,
    output logic                  stall,
    output logic [ADDR_BITS-1:0]  cache_addr,
    output logic                  cache_load,
    output logic                  cache_store,
    output logic                  cache_edit,
    output logic                  cache_invalid,
    output logic [2:0]            cache_u_b_h_w,
    output logic [31:0]           cache_din,
    input  logic                  cache_hit,
    input  logic                  cache_valid,
    input  logic                  cache_dirty,
    input  logic [ADDR_BITS-10:0] cache_tag,
    input  logic [31:0]           cache_dout,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_ack_i
);
    localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = CNT_W + 2;
    localparam int unsigned LINE_W = ADDR_BITS - OFF_W;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [2:0]       UBHW_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_PRE_BACK, S_BACK, S_FILL, S_WAIT
    } state_t;

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_word_cnt, w_word_cnt_next;
    logic [TAG_W-1:0]     r_victim_tag;
    logic [LINE_W-1:0]    r_req_line;
    logic [31:0]          r_data_r;
    logic                 w_req;
    logic                 w_hit;
    logic [ADDR_BITS-1:0] w_victim_addr;
    logic [ADDR_BITS-1:0] w_fill_addr;

    assign w_req         = en_r | en_w;
    assign w_hit         = (r_state == S_LOOKUP) & cache_hit;
    assign stall         = w_req & ~w_hit;
    assign data_r        = r_data_r;
    assign cache_invalid = 1'b0;
    // Request line is latched at lookup so a withdrawn request cannot corrupt a refill.
    assign w_victim_addr = {r_victim_tag, r_req_line[IDX_W-1:0], r_word_cnt, 2'b00};
    assign w_fill_addr   = {r_req_line, r_word_cnt, 2'b00};

    // State, counter and latched request/victim information.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_victim_tag <= '0;
            r_req_line   <= '0;
            r_data_r     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_word_cnt <= w_word_cnt_next;
            if (r_state == S_LOOKUP && w_req) begin
                if (cache_hit) begin
                    r_data_r <= cache_dout;
                end else begin
                    r_req_line <= addr_rw[ADDR_BITS-1:OFF_W];
                    if (cache_valid & cache_dirty) begin
                        r_victim_tag <= cache_tag;
                    end
                end
            end
        end
    end

    // Next-state, cache command and memory port decode.
    always_comb begin
        w_state_next    = r_state;
        w_word_cnt_next = r_word_cnt;
        cache_addr      = addr_rw;
        cache_load      = 1'b0;
        cache_store     = 1'b0;
        cache_edit      = 1'b0;
        cache_u_b_h_w   = u_b_h_w;
        cache_din       = data_w;
        mem_cs_o        = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_data_o      = '0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    // A combined read/write request is serviced as a write.
                    cache_load   = en_r & ~en_w;
                    cache_edit   = en_w;
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_req || cache_hit) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_word_cnt_next = '0;
                    w_state_next    = (cache_valid & cache_dirty) ? S_PRE_BACK : S_FILL;
                end
            end
            S_PRE_BACK: begin
                // Present the victim word; its data appears on cache_dout next cycle.
                cache_addr    = w_victim_addr;
                cache_u_b_h_w = UBHW_WORD;
                w_state_next  = S_BACK;
            end
            S_BACK: begin
                cache_addr    = w_victim_addr;
                cache_u_b_h_w = UBHW_WORD;
                mem_cs_o      = 1'b1;
                mem_we_o      = 1'b1;
                mem_addr_o    = w_victim_addr;
                mem_data_o    = cache_dout;
                if (mem_ack_i) begin
                    if (r_word_cnt == LAST_WORD) begin
                        w_word_cnt_next = '0;
                        w_state_next    = S_FILL;
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_W'(1);
                        w_state_next    = S_PRE_BACK;
                    end
                end
            end
            S_FILL: begin
                cache_addr = w_fill_addr;
                mem_cs_o   = 1'b1;
                mem_addr_o = w_fill_addr;
                if (mem_ack_i) begin
                    cache_store     = 1'b1;
                    cache_din       = mem_data_i;
                    cache_u_b_h_w   = UBHW_WORD;
                    w_word_cnt_next = r_word_cnt + CNT_W'(1);
                    if (r_word_cnt == LAST_WORD) begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Reset silences every strobe in the same cycle it is asserted.
        if (rst) begin
            cache_load  = 1'b0;
            cache_store = 1'b0;
            cache_edit  = 1'b0;
            mem_cs_o    = 1'b0;
            mem_we_o    = 1'b0;
        end
    end
endmodule
